mist32_device_display_busif: RTL

MIST32_DEVICE_DISPLAY_BUSIF -- requirements
Module: mist32_device_display_busif

---
 rtl/mist32_display_busif_pkg.sv | 33 +++
 rtl/mist32_sync_fifo.sv | 47 ++++
 rtl/mist32_device_display_busif.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mist32_display_busif_pkg.sv
// Shared encodings for the MIST32 display bus interface: region classes, IRQ codes,
// IRQ FSM states and special-region word indices.
package mist32_display_busif_pkg;

  typedef enum logic [1:0] {
    RegionSpecial,
    RegionDisplay,
    RegionIllegal
  } region_e;

  typedef enum logic [1:0] {
    IrqIdle,
    IrqPend,
    IrqWait
  } irq_state_e;

  localparam logic [23:0] IrqCodeIllegal  = 24'h000000;
  localparam logic [23:0] IrqCodeDispRead = 24'h000001;

  localparam logic [7:0] SpecialWordLimit = 8'd0;
  localparam logic [7:0] SpecialWordType  = 8'd1;
  localparam logic [7:0] SpecialWordCount = 8'd2;
  localparam logic [7:0] SpecialWordLost  = 8'd3;

  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] special_size,
                                            input logic [31:0] addr_limit);
    if (addr < special_size) return RegionSpecial;
    if (addr < addr_limit) return RegionDisplay;
    return RegionIllegal;
  endfunction

endpackage

// File: rtl/mist32_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so pointers wrap freely.
module mist32_sync_fifo #(
  parameter int unsigned WIDTH = 62,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr, w_rd;

  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_rd);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = (r_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/mist32_device_display_busif.sv
// MIST32 device bus slave posting display writes through a FIFO, with a small status region.
// Error IRQ reporting and the lost-IRQ counter exist only with MIST32_DISPLAY_BUSIF_IRQ_EN.
module mist32_device_display_busif
  import mist32_display_busif_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [31:0] SPECIAL_SIZE = 32'h0000_0400,
  parameter logic [31:0] ADDR_LIMIT   = 32'h0013_8400,
  parameter logic [31:0] DEVICE_TYPE  = 32'h0000_0002
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iDEV_REQ,
  output logic        oDEV_BUSY,
  input  logic        iDEV_RW,
  input  logic [31:0] iDEV_ADDR,
  input  logic [31:0] iDEV_DATA,
  output logic        oDEV_REQ,
  input  logic        iDEV_BUSY,
  output logic [31:0] oDEV_DATA,
  output logic        oDEV_IRQ_REQ,
  input  logic        iDEV_IRQ_BUSY,
  output logic [23:0] oDEV_IRQ_DATA,
  input  logic        iDEV_IRQ_ACK,
  output logic        oDISP_WR_REQ,
  input  logic        iDISP_WR_BUSY,
  output logic [29:0] oDISP_WR_ADDR,
  output logic [31:0] oDISP_WR_DATA
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_accept, w_push, w_pop, w_full, w_empty;
  logic [CW-1:0] w_count, w_count_next;
  logic [61:0]   w_head;
  region_e       w_region;
  logic [7:0]    w_word;
  logic [31:0]   w_rd_data;
  logic [15:0]   w_lost;

  logic          r_busy, r_req, r_skid_vld;
  logic [31:0]   r_data, r_skid_data;
  logic          w_req_next, w_skid_vld_next, w_busy_next;
  logic [31:0]   w_data_next, w_skid_data_next;

  assign w_accept     = iDEV_REQ && !r_busy;
  assign w_region     = decode_region(iDEV_ADDR, SPECIAL_SIZE, ADDR_LIMIT);
  assign w_word       = iDEV_ADDR[9:2];
  assign w_push       = w_accept && iDEV_RW && (w_region == RegionDisplay);
  assign w_pop        = !w_empty && !iDISP_WR_BUSY;
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

  mist32_sync_fifo #(
    .WIDTH (62),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (iCLOCK),
    .i_rst     (iRESET),
    .i_wr_en   (w_push),
    .i_wr_data ({iDEV_ADDR[31:2], iDEV_DATA}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign oDISP_WR_REQ  = !w_empty;
  assign oDISP_WR_ADDR = w_empty ? '0 : w_head[61:32];
  assign oDISP_WR_DATA = w_empty ? '0 : w_head[31:0];

  always_comb begin
    w_rd_data = '0;
    if (!iDEV_RW && (w_region == RegionSpecial)) begin
      case (w_word)
        SpecialWordLimit: w_rd_data = ADDR_LIMIT;
        SpecialWordType:  w_rd_data = DEVICE_TYPE;
        SpecialWordCount: w_rd_data = 32'(w_count);
        SpecialWordLost:  w_rd_data = {16'h0, w_lost};
        default:          w_rd_data = '0;
      endcase
    end
  end

  // An access accepted while the previous response is stalled parks in the skid slot.
  always_comb begin
    w_req_next       = r_req;
    w_data_next      = r_data;
    w_skid_vld_next  = r_skid_vld;
    w_skid_data_next = r_skid_data;
    if (r_req && iDEV_BUSY) begin
      if (w_accept) begin
        w_skid_vld_next  = 1'b1;
        w_skid_data_next = w_rd_data;
      end
    end else if (r_skid_vld) begin
      w_req_next      = 1'b1;
      w_data_next     = r_skid_data;
      w_skid_vld_next = 1'b0;
    end else begin
      w_req_next  = w_accept;
      w_data_next = w_accept ? w_rd_data : '0;
    end
    w_busy_next = (w_count_next == CW'(FIFO_DEPTH)) || w_skid_vld_next ||
                  (w_req_next && iDEV_BUSY);
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_busy      <= 1'b1;
      r_req       <= 1'b0;
      r_data      <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
    end else begin
      r_busy      <= w_busy_next;
      r_req       <= w_req_next;
      r_data      <= w_data_next;
      r_skid_vld  <= w_skid_vld_next;
      r_skid_data <= w_skid_data_next;
    end
  end

  assign oDEV_BUSY = r_busy;
  assign oDEV_REQ  = r_req;
  assign oDEV_DATA = r_data;

`ifdef MIST32_DISPLAY_BUSIF_IRQ_EN
  irq_state_e  r_irq_state, w_irq_state_next;
  logic [23:0] r_irq_code, w_err_code;
  logic [15:0] r_lost;
  logic        w_err, w_err_lost, w_lost_clr;

  assign w_err      = w_accept && ((w_region == RegionIllegal) ||
                                   ((w_region == RegionDisplay) && !iDEV_RW));
  assign w_err_code = (w_region == RegionIllegal) ? IrqCodeIllegal : IrqCodeDispRead;
  assign w_err_lost = w_err && (r_irq_state != IrqIdle);
  assign w_lost_clr = w_accept && iDEV_RW && (w_region == RegionSpecial) &&
                      (w_word == SpecialWordLost);

  always_comb begin
    w_irq_state_next = r_irq_state;
    oDEV_IRQ_REQ     = 1'b0;
    unique case (r_irq_state)
      IrqIdle: if (w_err) w_irq_state_next = IrqPend;
      IrqPend: begin
        oDEV_IRQ_REQ = !iDEV_IRQ_BUSY;
        if (!iDEV_IRQ_BUSY) w_irq_state_next = IrqWait;
      end
      IrqWait: if (iDEV_IRQ_ACK) w_irq_state_next = IrqIdle;
      default: w_irq_state_next = IrqIdle;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_irq_state <= IrqIdle;
      r_irq_code  <= '0;
      r_lost      <= '0;
    end else begin
      r_irq_state <= w_irq_state_next;
      if ((r_irq_state == IrqIdle) && w_err) r_irq_code <= w_err_code;
      if (w_lost_clr) r_lost <= '0;
      else if (w_err_lost && (r_lost != 16'hFFFF)) r_lost <= r_lost + 16'd1;
    end
  end

  assign oDEV_IRQ_DATA = (r_irq_state == IrqIdle) ? '0 : r_irq_code;
  assign w_lost        = r_lost;
`else
  logic w_unused_irq;
  assign w_unused_irq  = ^{iDEV_IRQ_BUSY, iDEV_IRQ_ACK, w_full};
  assign oDEV_IRQ_REQ  = 1'b0;
  assign oDEV_IRQ_DATA = '0;
  assign w_lost        = '0;
`endif

endmodule
